// File: rtl/sort_stream_checker_if.sv
// Stream bus carrying packet words into the sort checker.
// The master drives data and framing; the slave answers with ready.
interface sort_stream_checker_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] pkt_data;
    logic              pkt_sop;
    logic              pkt_eop;
    logic              pkt_val;
    logic              pkt_ready;

    modport master (
        output pkt_data, pkt_sop, pkt_eop, pkt_val,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data, pkt_sop, pkt_eop, pkt_val,
        output pkt_ready
    );
endinterface

// File: rtl/sort_stream_checker.sv
// Sort stream checker: consumes framed packets and verifies that the words
// in each packet are non-decreasing. It reports completed packets,
// framing, order and length errors, and throttles the stream with
// LFSR-driven backpressure when enabled.
module sort_stream_checker #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    sort_stream_checker_if.slave pkt,
    input  logic                 bp_en_i,
    output logic                 pkt_done_o,
    output logic [AWIDTH:0]      pkt_len_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_NO_SOP  = 3'd1,
        ERR_DUP_SOP = 3'd2,
        ERR_ORDER   = 3'd3,
        ERR_LEN_OVF = 3'd4
    } err_code_t;

    // Saturated packet length: exactly 2**AWIDTH words.
    localparam logic [AWIDTH:0] LEN_MAX = {1'b1, {AWIDTH{1'b0}}};

    state_t            state;
    state_t            state_next;
    logic [15:0]       lfsr;
    logic              accept;

    logic [AWIDTH:0]   len;
    logic [AWIDTH:0]   len_next;
    logic [DWIDTH-1:0] prev;
    logic [DWIDTH-1:0] prev_next;
    logic              ovf_seen;
    logic              ovf_seen_next;
    logic              ord_seen;
    logic              ord_seen_next;
    logic              done_now;
    err_code_t         code_now;
    logic              order_hit;
    logic              ovf_hit;

    // Backpressure source: Fibonacci LFSR, taps 16,14,13,11, free-running.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (!rst_n_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Ready is held low while in reset so nothing is taken during reset.
    assign pkt.pkt_ready = rst_n_i & ~(bp_en_i & lfsr[0] & lfsr[1]);
    assign accept        = pkt.pkt_val & pkt.pkt_ready;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a sop word always opens a packet, an eop word closes it.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        state_next = state;
        if (accept) begin
            unique case (state)
                IDLE:    if (pkt.pkt_sop && !pkt.pkt_eop) state_next = IN_PKT;
                IN_PKT:  state_next = pkt.pkt_eop ? IDLE : IN_PKT;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: per-word length/order bookkeeping and error classification.
    always_comb begin
        len_next      = len;
        prev_next     = prev;
        ovf_seen_next = ovf_seen;
        ord_seen_next = ord_seen;
        done_now      = 1'b0;
        code_now      = ERR_NONE;
        order_hit     = 1'b0;
        ovf_hit       = 1'b0;
        if (accept) begin
            if (pkt.pkt_sop) begin
                // A sop always starts fresh; inside a packet it abandons the old one.
                len_next      = (AWIDTH+1)'(1);
                prev_next     = pkt.pkt_data;
                ovf_seen_next = 1'b0;
                ord_seen_next = 1'b0;
                done_now      = pkt.pkt_eop;
                if (state == IN_PKT) code_now = ERR_DUP_SOP;
            end else if (state == IDLE) begin
                code_now = ERR_NO_SOP;
            end else begin
                order_hit     = (pkt.pkt_data < prev) && !ord_seen;
                ovf_hit       = (len == LEN_MAX) && !ovf_seen;
                len_next      = (len == LEN_MAX) ? LEN_MAX : len + (AWIDTH+1)'(1);
                prev_next     = pkt.pkt_data;
                ovf_seen_next = ovf_seen | ovf_hit;
                ord_seen_next = ord_seen | order_hit;
                done_now      = pkt.pkt_eop;
                if (ovf_hit)        code_now = ERR_LEN_OVF;
                else if (order_hit) code_now = ERR_ORDER;
            end
        end
    end

    // Packet bookkeeping registers and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len        <= '0;
            prev       <= '0;
            ovf_seen   <= 1'b0;
            ord_seen   <= 1'b0;
            pkt_done_o <= 1'b0;
            pkt_len_o  <= '0;
            pkt_cnt_o  <= '0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_cnt_o  <= '0;
        end else begin
            len        <= len_next;
            prev       <= prev_next;
            ovf_seen   <= ovf_seen_next;
            ord_seen   <= ord_seen_next;
            pkt_done_o <= done_now;
            err_o      <= (code_now != ERR_NONE);
            if (done_now) begin
                pkt_len_o <= len_next;
                if (pkt_cnt_o != '1) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
            end
            if (code_now != ERR_NONE) begin
                err_code_o <= code_now;
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sort_stream_checker.sv
// Self-checking bench for sort_stream_checker: directed scenarios plus a
// randomized backpressured stream, all compared against a queue-based model.
module tb_sort_stream_checker;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int CW = 16;
    localparam int MAXLEN = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          bp_en;
    logic          pkt_done;
    logic [AW:0]   pkt_len;
    logic [CW-1:0] pkt_cnt;
    logic          err;
    logic [2:0]    err_code;
    logic [CW-1:0] err_cnt;

    sort_stream_checker_if #(.DWIDTH(DW)) bus ();

    sort_stream_checker #(.DWIDTH(DW), .AWIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .pkt        (bus),
        .bp_en_i    (bp_en),
        .pkt_done_o (pkt_done),
        .pkt_len_o  (pkt_len),
        .pkt_cnt_o  (pkt_cnt),
        .err_o      (err),
        .err_code_o (err_code),
        .err_cnt_o  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int done_seen;
    int err_seen;
    int stalls;
    logic last_acc;

    // Reference model state: the open packet is simply the list of its words.
    logic [15:0]   m_lfsr;
    logic          m_ready;
    logic          m_open;
    logic [DW-1:0] m_pkt[$];
    logic          m_ovf_seen;
    logic          m_ord_seen;
    logic          e_done;
    int            e_len;
    int            e_pcnt;
    logic          e_err;
    int            e_code;
    int            e_ecnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic model_reset();
        m_lfsr     = 16'hACE1;
        m_open     = 1'b0;
        m_pkt.delete();
        m_ovf_seen = 1'b0;
        m_ord_seen = 1'b0;
        e_done     = 1'b0;
        e_len      = 0;
        e_pcnt     = 0;
        e_err      = 1'b0;
        e_code     = 0;
        e_ecnt     = 0;
    endtask

    // One rising edge of the model: apply the rules to an accepted word.
    task automatic model_clock(input logic acc, input logic s, input logic e, input logic [DW-1:0] d);
        int  code;
        logic ord;
        logic ovf;
        code   = 0;
        ord    = 1'b0;
        ovf    = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (acc) begin
            if (!m_open && !s) begin
                code = 1;
            end else if (s) begin
                if (m_open) code = 2;
                m_pkt.delete();
                m_pkt.push_back(d);
                m_open     = 1'b1;
                m_ovf_seen = 1'b0;
                m_ord_seen = 1'b0;
            end else begin
                if (d < m_pkt[$] && !m_ord_seen) begin
                    ord        = 1'b1;
                    m_ord_seen = 1'b1;
                end
                m_pkt.push_back(d);
                if (m_pkt.size() > MAXLEN && !m_ovf_seen) begin
                    ovf        = 1'b1;
                    m_ovf_seen = 1'b1;
                end
                if (ovf)      code = 4;
                else if (ord) code = 3;
            end
            if (m_open && e) begin
                e_done = 1'b1;
                e_len  = (m_pkt.size() > MAXLEN) ? MAXLEN : m_pkt.size();
                if (e_pcnt != 16'hFFFF) e_pcnt++;
                m_open = 1'b0;
                m_pkt.delete();
            end
            if (code != 0) begin
                e_err  = 1'b1;
                e_code = code;
                if (e_ecnt != 16'hFFFF) e_ecnt++;
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic cycle(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
        bus.pkt_val  = v;
        bus.pkt_sop  = s;
        bus.pkt_eop  = e;
        bus.pkt_data = d;
        #1;
        m_ready = !(bp_en && m_lfsr[0] && m_lfsr[1]);
        check("ready", bus.pkt_ready, m_ready);
        if (v && !m_ready) stalls++;
        last_acc = v && m_ready;
        @(posedge clk);
        model_clock(last_acc, s, e, d);
        #1;
        check("pkt_done", pkt_done, e_done);
        check("pkt_len", pkt_len, e_len);
        check("pkt_cnt", pkt_cnt, e_pcnt);
        check("err", err, e_err);
        check("err_code", err_code, e_code);
        check("err_cnt", err_cnt, e_ecnt);
        if (pkt_done) done_seen++;
        if (err) err_seen++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'(($urandom)), 1'(($urandom)), DW'($urandom));
    endtask

    // Hold a word on the bus until the model says it was taken.
    task automatic send_word(input logic [DW-1:0] d, input logic s, input logic e);
        logic taken;
        taken = 1'b0;
        for (int t = 0; t < 100 && !taken; t++) begin
            cycle(1'b1, s, e, d);
            taken = last_acc;
        end
        check("word_accepted", taken, 1'b1);
    endtask

    // Asynchronous reset asserted between edges, held for two cycles.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", bus.pkt_ready, 1'b0);
        check("rst_done", pkt_done, 1'b0);
        check("rst_len", pkt_len, 0);
        check("rst_pcnt", pkt_cnt, 0);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 0);
        check("rst_ecnt", err_cnt, 0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        done_seen    = 0;
        err_seen     = 0;
        stalls       = 0;
        last_acc     = 1'b0;
        rst_n        = 1'b0;
        bp_en        = 1'b0;
        bus.pkt_val  = 1'b0;
        bus.pkt_sop  = 1'b0;
        bus.pkt_eop  = 1'b0;
        bus.pkt_data = '0;
        model_reset();
        @(negedge clk);
        apply_reset();
        idle(2);

        // Sorted packet with a repeated value.
        done_seen = 0;
        send_word(8'd3, 1'b1, 1'b0);
        send_word(8'd5, 1'b0, 1'b0);
        send_word(8'd5, 1'b0, 1'b0);
        send_word(8'd9, 1'b0, 1'b1);
        idle(1);
        check("sorted_done_pulses", done_seen, 1);
        check("sorted_len", pkt_len, 4);
        check("sorted_cnt", pkt_cnt, 1);
        check("sorted_ecnt", err_cnt, 0);

        // Single-word packet.
        send_word(8'd7, 1'b1, 1'b1);
        idle(1);
        check("single_len", pkt_len, 1);
        check("single_cnt", pkt_cnt, 2);
        check("single_ready_idle", bus.pkt_ready, 1'b1);

        // Descending packet: one ORDER error only.
        done_seen = 0;
        err_seen  = 0;
        send_word(8'd4, 1'b1, 1'b0);
        send_word(8'd2, 1'b0, 1'b0);
        send_word(8'd1, 1'b0, 1'b1);
        idle(1);
        check("order_err_pulses", err_seen, 1);
        check("order_code", err_code, 3);
        check("order_ecnt", err_cnt, 1);
        check("order_done_pulses", done_seen, 1);
        check("order_len", pkt_len, 3);

        // Word without sop, then a sop in the middle of a packet.
        send_word(8'd9, 1'b0, 1'b0);
        check("nosop_code", err_code, 1);
        send_word(8'd1, 1'b1, 1'b0);
        send_word(8'd2, 1'b0, 1'b0);
        send_word(8'd3, 1'b1, 1'b0);
        check("dupsop_code", err_code, 2);
        send_word(8'd4, 1'b0, 1'b1);
        idle(1);
        check("dupsop_ecnt", err_cnt, 3);
        check("dupsop_cnt", pkt_cnt, 4);
        check("dupsop_len", pkt_len, 2);

        // One word past the maximum length.
        err_seen = 0;
        for (int i = 0; i <= MAXLEN; i++)
            send_word(DW'(i), i == 0, i == MAXLEN);
        idle(1);
        check("ovf_code", err_code, 4);
        check("ovf_err_pulses", err_seen, 1);
        check("ovf_len", pkt_len, MAXLEN);
        check("ovf_cnt", pkt_cnt, 5);

        // Reset in the middle of a packet, then a clean packet.
        send_word(8'd1, 1'b1, 1'b0);
        send_word(8'd2, 1'b0, 1'b0);
        apply_reset();
        send_word(8'd5, 1'b1, 1'b0);
        send_word(8'd6, 1'b0, 1'b0);
        send_word(8'd7, 1'b0, 1'b1);
        idle(1);
        check("post_rst_cnt", pkt_cnt, 1);
        check("post_rst_len", pkt_len, 3);
        check("post_rst_ecnt", err_cnt, 0);

        // Random stream under backpressure.
        bp_en  = 1'b1;
        stalls = 0;
        for (int p = 0; p < 80; p++) begin
            int       n;
            logic     scramble;
            logic [DW-1:0] d;
            n        = $urandom_range(1, 8);
            scramble = ($urandom_range(0, 3) == 0);
            d        = DW'($urandom_range(0, 60));
            for (int w = 0; w < n; w++) begin
                logic s;
                s = (w == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
                idle($urandom_range(0, 2));
                send_word(d, s, w == n - 1);
                d = scramble ? DW'($urandom) : d + DW'($urandom_range(0, 5));
            end
        end
        idle(2);
        check("bp_stalls_seen", stalls > 0, 1'b1);
        check("bp_final_cnt", pkt_cnt, e_pcnt);
        check("bp_final_ecnt", err_cnt, e_ecnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
